// File: rtl/isqrt_rr_share.sv
// rtl/isqrt_rr_share.sv - round-robin sharing of one pipelined isqrt among N_REQ requesters
//
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   req_vld/req_x   per-requester operand offer (requester i in req_x[i*WIDTH +: WIDTH])
//   req_rdy         one-hot-or-zero combinational grant
//   sq_vld/sq_x     registered issue to the external isqrt
//   sq_res_vld/sq_res  result from the external isqrt, ISQRT_LATENCY cycles after issue
//   rsp_vld/rsp_y   registered one-hot result strobe and shared result bus
//   err             sticky: sq_res_vld disagreed with the ownership pipeline
module isqrt_rr_share #(
    parameter int N_REQ         = 3,
    parameter int WIDTH         = 32,
    parameter int ISQRT_LATENCY = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_vld,
    input  logic [N_REQ*WIDTH-1:0]   req_x,
    output logic [N_REQ-1:0]         req_rdy,
    output logic                     sq_vld,
    output logic [WIDTH-1:0]         sq_x,
    input  logic                     sq_res_vld,
    input  logic [WIDTH/2-1:0]       sq_res,
    output logic [N_REQ-1:0]         rsp_vld,
    output logic [WIDTH/2-1:0]       rsp_y,
    output logic                     err
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int L  = ISQRT_LATENCY;

    logic [PW-1:0] ptr;
    logic [PW-1:0] gnt_idx;
    logic          gnt_any;
    logic [PW-1:0] tag_in;

    // Ownership pipeline: stage 0 is fed from the issue register, stage L-1
    // lines up with sq_res_vld of the same operation.
    logic [L-1:0]  tv;
    logic [PW-1:0] tt [L];

    logic          tail_vld;
    logic [PW-1:0] tail_tag;
    logic [N_REQ-1:0] tail_oh;

    assign tail_vld = tv[L-1];
    assign tail_tag = tt[L-1];

    // Search ptr, ptr+1, ... (mod N_REQ) for the first valid requester.
    always_comb begin
        logic [PW:0] sum;
        req_rdy = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(N_REQ)) begin
                sum = sum - (PW+1)'(N_REQ);
            end
            if (!gnt_any && req_vld[sum[PW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = sum[PW-1:0];
            end
        end
        req_rdy[gnt_idx] = gnt_any;
    end

    // A result with no owner on record is steered to requester 0.
    always_comb begin
        tail_oh = '0;
        tail_oh[tail_vld ? tail_tag : '0] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr     <= '0;
            sq_vld  <= 1'b0;
            sq_x    <= '0;
            tag_in  <= '0;
            tv      <= '0;
            for (int j = 0; j < L; j++) begin
                tt[j] <= '0;
            end
            rsp_vld <= '0;
            rsp_y   <= '0;
            err     <= 1'b0;
        end else begin
            sq_vld <= gnt_any;
            if (gnt_any) begin
                ptr    <= (gnt_idx == PW'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
                sq_x   <= req_x[gnt_idx*WIDTH +: WIDTH];
                tag_in <= gnt_idx;
            end

            // Tags only move along with a valid so idle stages do not toggle.
            tv[0] <= sq_vld;
            if (sq_vld) begin
                tt[0] <= tag_in;
            end
            for (int j = 1; j < L; j++) begin
                tv[j] <= tv[j-1];
                if (tv[j-1]) begin
                    tt[j] <= tt[j-1];
                end
            end

            rsp_vld <= sq_res_vld ? tail_oh : '0;
            if (sq_res_vld) begin
                rsp_y <= sq_res;
            end
            if (sq_res_vld != tail_vld) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_isqrt_rr_share.sv
// tb/tb_isqrt_rr_share.sv - randomized self-checking bench for isqrt_rr_share
module tb_isqrt_rr_share;

    localparam int N   = 3;
    localparam int W   = 32;
    localparam int HW  = W / 2;
    localparam int LAT = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_vld;
    logic [N*W-1:0] req_x;
    logic [N-1:0]   req_rdy;
    logic           sq_vld;
    logic [W-1:0]   sq_x;
    logic           sq_res_vld;
    logic [HW-1:0]  sq_res;
    logic [N-1:0]   rsp_vld;
    logic [HW-1:0]  rsp_y;
    logic           err;

    always #5 clk = ~clk;

    isqrt_rr_share #(.N_REQ(N), .WIDTH(W), .ISQRT_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_vld(req_vld), .req_x(req_x), .req_rdy(req_rdy),
        .sq_vld(sq_vld), .sq_x(sq_x),
        .sq_res_vld(sq_res_vld), .sq_res(sq_res),
        .rsp_vld(rsp_vld), .rsp_y(rsp_y), .err(err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Bit-serial root for the stand-in isqrt.
    function automatic logic [HW-1:0] stub_sqrt(input logic [W-1:0] x);
        logic [HW-1:0] r = '0;
        logic [HW-1:0] t;
        for (int b = HW - 1; b >= 0; b--) begin
            t = r | (HW'(1) << b);
            if (longint'(t) * longint'(t) <= longint'(x)) r = t;
        end
        return r;
    endfunction

    // Reference root from real arithmetic, corrected to the exact floor.
    function automatic logic [HW-1:0] ref_sqrt(input logic [W-1:0] x);
        longint r;
        longint xl;
        xl = longint'(x);
        r  = longint'($floor($sqrt(real'(xl))));
        while ((r + 1) * (r + 1) <= xl) r++;
        while (r * r > xl) r--;
        return r[HW-1:0];
    endfunction

    // Stand-in isqrt: fixed LAT-cycle delay line, reset with the same rst.
    logic         st_v [LAT];
    logic [W-1:0] st_x [LAT];
    logic         inj = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int j = 0; j < LAT; j++) begin
                st_v[j] <= 1'b0;
                st_x[j] <= '0;
            end
        end else begin
            st_v[0] <= sq_vld;
            st_x[0] <= sq_x;
            for (int j = 1; j < LAT; j++) begin
                st_v[j] <= st_v[j-1];
                st_x[j] <= st_x[j-1];
            end
        end
    end

    assign sq_res_vld = st_v[LAT-1] | inj;
    assign sq_res     = stub_sqrt(st_x[LAT-1]);

    // Scoreboard: every expected grant queues {owner, root, due cycle}.
    typedef struct {
        int            owner;
        logic [HW-1:0] y;
        int            due;
    } exp_t;

    exp_t         q[$];
    int           gseq[$];
    int           cyc = 0;
    int           model_ptr = 0;
    logic         mon_en = 1'b1;
    logic         gap_chk = 1'b0;
    logic [W-1:0] prev_sq_x = '0;
    logic [N-1:0] hs = '0;
    logic [N-1:0] e_rdy;
    int           g;
    int           grants [N];
    int           rsps [N];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_en) begin
            if (!rst) begin
                q.delete();
                model_ptr = 0;
                prev_sq_x = '0;
                hs = '0;
                for (int i = 0; i < N; i++) begin
                    grants[i] = 0;
                    rsps[i]   = 0;
                end
            end else begin
                e_rdy = '0;
                g = -1;
                for (int k = 0; k < N; k++) begin
                    if (g < 0 && req_vld[(model_ptr + k) % N]) g = (model_ptr + k) % N;
                end
                if (g >= 0) e_rdy[g] = 1'b1;
                chk("req_rdy", 64'(req_rdy), 64'(e_rdy));
                if (g >= 0) begin
                    q.push_back('{g, ref_sqrt(req_x[g*W +: W]), cyc + LAT + 2});
                    gseq.push_back(g);
                    grants[g]++;
                    model_ptr = (g + 1) % N;
                end
                hs = req_vld & req_rdy;

                if (q.size() > 0 && q[0].due == cyc) begin
                    chk("rsp_vld", 64'(rsp_vld), 64'(1) << q[0].owner);
                    chk("rsp_y", 64'(rsp_y), 64'(q[0].y));
                    rsps[q[0].owner]++;
                    void'(q.pop_front());
                end else begin
                    chk("rsp_idle", 64'(rsp_vld), 64'(0));
                end

                if (!sq_vld) chk("sq_x_hold", 64'(sq_x), 64'(prev_sq_x));
                prev_sq_x = sq_x;
                if (gap_chk) chk("sq_vld_gap", 64'(sq_vld), 64'(1));
                chk("err_clear", 64'(err), 64'(0));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_vld = '0;
        rst = 1'b0;
        repeat (3) step();
        chk("rst_sq_vld", 64'(sq_vld), 64'(0));
        chk("rst_sq_x", 64'(sq_x), 64'(0));
        chk("rst_rsp_vld", 64'(rsp_vld), 64'(0));
        chk("rst_rsp_y", 64'(rsp_y), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_req_rdy", 64'(req_rdy), 64'(0));
        rst = 1'b1;
    endtask

    task automatic drain();
        req_vld = '0;
        repeat (LAT + 4) step();
        chk("drained", 64'(q.size()), 64'(0));
    endtask

    logic [W-1:0] vals [6];
    int           nn [N];

    initial begin
        rst = 1'b0;
        req_vld = '0;
        req_x = '0;
        vals[0] = 32'd0;   vals[1] = 32'd1;   vals[2] = 32'd4;
        vals[3] = 32'd16;  vals[4] = 32'd255; vals[5] = 32'hFFFF_FFFF;

        // Single requester: one grant per cycle, roots back in order.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            req_vld = 3'b010;
            req_x[W +: W] = vals[k];
            step();
        end
        drain();
        chk("single_rsp_count", 64'(rsps[1]), 64'(6));
        chk("single_other_rsp", 64'(rsps[0] + rsps[2]), 64'(0));

        // All three continuously valid: strict 0,1,2 rotation, no issue gaps.
        do_reset();
        gseq.delete();
        for (int i = 0; i < N; i++) begin
            nn[i] = 0;
            req_x[i*W +: W] = W'(i * 1000);
        end
        req_vld = 3'b111;
        repeat (30) begin
            step();
            gap_chk = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (hs[i]) begin
                    nn[i]++;
                    req_x[i*W +: W] = W'(i * 1000 + nn[i] * nn[i]);
                end
            end
        end
        req_vld = '0;
        gap_chk = 1'b0;
        for (int k = 0; k < 9; k++) chk("rotation", 64'(gseq[k]), 64'(k % 3));
        drain();

        // 0 and 2 contend, then 1 joins after a grant to 0 left ptr at 1.
        do_reset();
        gseq.delete();
        req_x = {$urandom, $urandom, $urandom};
        req_vld = 3'b101;
        repeat (3) step();
        req_vld = 3'b111;
        repeat (3) step();
        req_vld = '0;
        chk("skip_g0", 64'(gseq[0]), 64'(0));
        chk("skip_g1", 64'(gseq[1]), 64'(2));
        chk("skip_g2", 64'(gseq[2]), 64'(0));
        chk("join_g3", 64'(gseq[3]), 64'(1));
        chk("join_g4", 64'(gseq[4]), 64'(2));
        chk("join_g5", 64'(gseq[5]), 64'(0));
        drain();

        // Sparse random valids; a requester may drop valid without a grant.
        do_reset();
        repeat (10000) begin
            for (int i = 0; i < N; i++) begin
                req_vld[i] = ($urandom_range(0, 99) < 30);
                req_x[i*W +: W] = $urandom;
            end
            step();
        end
        drain();
        for (int i = 0; i < N; i++) chk("rand_count", 64'(rsps[i]), 64'(grants[i]));

        // Reset with five operations in flight: none of them may come back.
        do_reset();
        req_vld = 3'b001;
        for (int k = 0; k < 5; k++) begin
            req_x[0 +: W] = $urandom;
            step();
        end
        req_vld = '0;
        step();
        do_reset();
        repeat (LAT + 6) step();
        req_vld = 3'b100;
        for (int k = 0; k < 3; k++) begin
            req_x[2*W +: W] = $urandom;
            step();
        end
        drain();
        chk("post_rst_count", 64'(rsps[2]), 64'(3));
        chk("post_rst_other", 64'(rsps[0] + rsps[1]), 64'(0));

        // Spurious result with an empty ownership pipeline.
        mon_en = 1'b0;
        chk("pre_inj_err", 64'(err), 64'(0));
        inj = 1'b1;
        step();
        inj = 1'b0;
        chk("inj_err", 64'(err), 64'(1));
        chk("inj_rsp_owner", 64'(rsp_vld), 64'(1));
        repeat (5) begin
            step();
            chk("err_sticky", 64'(err), 64'(1));
        end
        mon_en = 1'b1;
        do_reset();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        n_bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
